iram_fetch_ctrl: RTL
====================

IRAM_FETCH_CTRL -- requirements
Module: iram_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the byte address of the first fetch after RESET or restart.
REQ-002 SHALL have parameter HALT_WORD, default 16'h0000, meaning the instruction encoding that stops fetch (unprogrammed IRAM entries read 0).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  pulse: begin running from IDLE, or restart from HALT.
REQ-006 SHALL have port STEP  input  1  pulse: fetch exactly one instruction while in IDLE.
REQ-007 SHALL have port STALL  input  1  level: freeze fetch and IR while in RUN.
REQ-008 SHALL have port BR_TAKEN  input  1  redirect fetch to BR_TARGET.
REQ-009 SHALL have port BR_TARGET  input  8  branch byte address.
REQ-010 SHALL have port IMEM_Q  input  16  IRAM read data, combinational from IMEM_ADDR.
REQ-011 SHALL have port IMEM_ADDR  output  8  IRAM byte address, equal to the fetch PC register.
REQ-012 SHALL have port IR  output  16  the latched instruction.
REQ-013 SHALL have port IR_PC  output  8  the byte address IR was fetched from.
REQ-014 SHALL have port IR_VALID  output  1  high when IR holds a live instruction for the datapath.
REQ-015 SHALL have port HALTED  output  1  high while in state HALT.

Function
REQ-016 SHALL implement states IDLE, RUN and HALT, and SHALL enter IDLE on reset.
REQ-017 In IDLE, START SHALL move the block to RUN without fetching in that cycle; STEP without START SHALL perform one fetch and remain in IDLE; START has priority over STEP.
REQ-018 A fetch SHALL load IR<=IMEM_Q, IR_PC<=fetch PC and IR_VALID<=1, and SHALL advance fetch PC by 2 modulo 256 (8'hFE wraps to 8'h00).
REQ-019 In RUN, each cycle with STALL=0 and BR_TAKEN=0 SHALL perform one fetch, giving one instruction per cycle and 1-cycle latency from IMEM_ADDR to IR.
REQ-020 In RUN with STALL=1 and BR_TAKEN=0, fetch PC, IR, IR_PC and IR_VALID SHALL all hold.
REQ-021 In RUN or IDLE, BR_TAKEN=1 SHALL override STALL and STEP, set fetch PC<={BR_TARGET[7:1],1'b0}, clear IR_VALID (flush), and leave the state unchanged.
REQ-022 When a fetch (RUN or STEP) sees IMEM_Q==HALT_WORD, the block SHALL enter HALT, clear IR_VALID, not advance fetch PC, and leave IR unchanged.
REQ-023 In HALT, the block SHALL ignore STALL, BR_TAKEN and STEP; START SHALL set fetch PC<=RESET_PC and move to RUN.
REQ-024 In IDLE, IR_VALID SHALL be high for exactly the one cycle following a STEP fetch and low otherwise.
REQ-025 Priority each cycle SHALL be: RESET > HALT-word detection > BR_TAKEN > STALL > normal fetch.
REQ-026 HALTED SHALL equal (state==HALT) and SHALL be driven from a register, with no combinational path from any input.

Reset
REQ-027 When RESET is high at a rising edge, the block SHALL set state=IDLE, fetch PC=RESET_PC, IR=16'h0000, IR_PC=8'h00, IR_VALID=0 and HALTED=0.
REQ-028 RESET SHALL override all other inputs in the same cycle, including during a stall, a branch or a halt.
REQ-029 IMEM_ADDR SHALL read RESET_PC in the first cycle after reset.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), the instruction width (16), the address width (8) and the PC increment (2).
REQ-031 The block SHALL be a single module with no sub-modules, and the next-PC logic SHALL be an internal always block.
REQ-032 The unused 2-bit state encoding 2'd3 SHALL recover to IDLE.

Verification
REQ-033 Bench SHALL cover reset, START, then the program 8'h00:1234, 8'h02:5678, 8'h04:0000 -> IR=1234/IR_PC=00, then IR=5678/IR_PC=02 on consecutive cycles, then HALTED=1, IR_VALID=0, IMEM_ADDR=04.
REQ-034 Bench SHALL cover STALL=1 for 3 cycles mid-run at fetch PC 8'h06 -> IMEM_ADDR stays 06 and IR, IR_PC and IR_VALID are unchanged; the fetch resumes the cycle STALL drops.
REQ-035 Bench SHALL cover BR_TAKEN=1 with BR_TARGET=8'h21 while STALL=1 -> the next IMEM_ADDR is 8'h20 and IR_VALID=0 for one cycle.
REQ-036 Bench SHALL cover wrap-around with fetch PC 8'hFE and nonzero words -> the next IMEM_ADDR is 8'h00.
REQ-037 Bench SHALL cover STEP twice in IDLE -> two single-cycle IR_VALID pulses with IR_PC=00 then 02, and the state stays IDLE.
REQ-038 Bench SHALL cover START while HALTED=1 -> IMEM_ADDR=RESET_PC and HALTED=0 next cycle; then RESET asserted mid-run -> all outputs at their reset values in the same cycle.

Source files
------------

// File: rtl/iram_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-RAM fetch controller.
// State encoding, bus widths and the PC step live here so bench and RTL agree.
package iram_fetch_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam logic [ADDR_W-1:0] PC_INC = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Instructions are 16-bit, so byte addresses are always even.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/iram_fetch_ctrl_if.sv
// Control, IRAM and instruction-register signals of the fetch controller.
// The controller takes the slave side; the sequencer/IRAM side takes master.
interface iram_fetch_ctrl_if;
  import iram_fetch_ctrl_pkg::*;

  logic               START;
  logic               STEP;
  logic               STALL;
  logic               BR_TAKEN;
  logic [ADDR_W-1:0]  BR_TARGET;
  logic [INSTR_W-1:0] IMEM_Q;
  logic [ADDR_W-1:0]  IMEM_ADDR;
  logic [INSTR_W-1:0] IR;
  logic [ADDR_W-1:0]  IR_PC;
  logic               IR_VALID;
  logic               HALTED;

  modport slave (
    input  START, STEP, STALL, BR_TAKEN, BR_TARGET, IMEM_Q,
    output IMEM_ADDR, IR, IR_PC, IR_VALID, HALTED
  );

  modport master (
    output START, STEP, STALL, BR_TAKEN, BR_TARGET, IMEM_Q,
    input  IMEM_ADDR, IR, IR_PC, IR_VALID, HALTED
  );

endinterface

// File: rtl/iram_fetch_ctrl.sv
// Fetch controller: IDLE/RUN/HALT sequencing of a 16-bit instruction RAM into IR.
// One fetch per cycle in RUN, 1-cycle IMEM_ADDR->IR latency; STALL freezes, BR_TAKEN flushes.
module iram_fetch_ctrl
  import iram_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'h0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  iram_fetch_ctrl_if.slave      bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_vld_q, ir_vld_d;
  logic               halted_q, halted_d;

  logic fetch_try, hit_halt, do_fetch, do_flush, do_hold, do_restart;

  // A fetch is attempted in RUN, or for a STEP in IDLE that START does not pre-empt.
  assign fetch_try = (state_q == ST_RUN) ||
                     ((state_q == ST_IDLE) && bus.STEP && !bus.START);
  assign hit_halt  = fetch_try && (bus.IMEM_Q == HALT_WORD);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_halt) begin
          state_d = ST_HALT;
        end else if (!bus.BR_TAKEN && bus.START) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hit_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.START) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath control decode
  always_comb begin
    do_flush   = 1'b0;
    do_hold    = 1'b0;
    do_restart = 1'b0;
    case (state_q)
      ST_IDLE: do_flush = !hit_halt && bus.BR_TAKEN;
      ST_RUN: begin
        do_flush = !hit_halt && bus.BR_TAKEN;
        do_hold  = !hit_halt && !bus.BR_TAKEN && bus.STALL;
      end
      ST_HALT: do_restart = bus.START;
      default: ;
    endcase
    do_fetch = fetch_try && !hit_halt && !do_flush && !do_hold;
    // IR_VALID only survives a stall; every other non-fetch cycle drops it.
    ir_vld_d = do_hold ? ir_vld_q : do_fetch;
    halted_d = (state_d == ST_HALT);
  end

  // Next fetch PC
  always_comb begin
    pc_d = pc_q;
    if (do_restart) begin
      pc_d = RESET_PC;
    end else if (do_flush) begin
      pc_d = align_pc(bus.BR_TARGET);
    end else if (do_fetch) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      ir_pc_q  <= '0;
      ir_vld_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_vld_q <= ir_vld_d;
      halted_q <= halted_d;
      if (do_fetch) begin
        ir_q    <= bus.IMEM_Q;
        ir_pc_q <= pc_q;
      end
    end
  end

  assign bus.IMEM_ADDR = pc_q;
  assign bus.IR        = ir_q;
  assign bus.IR_PC     = ir_pc_q;
  assign bus.IR_VALID  = ir_vld_q;
  assign bus.HALTED    = halted_q;

endmodule
